sys_bridge: RTL and testbench

- CPU-side initiator for timer/counter (TC) style word-addressed slaves: Addr[31:2], WE, Din, Dout, IRQ.
- Takes one CPU load/store request, decodes it onto one of two device ports, and returns read data or an error after a fixed latency.
- Registers device IRQ lines into the hardware-interrupt vector consumed by CP0.
- Sits between the MEM stage and the peripheral devices.

---
 rtl/bridge_pkg.sv | 24 ++
 rtl/bridge_decode.sv | 41 ++++
 rtl/sys_bridge.sv | 138 +++++++++++++
 tb/tb_sys_bridge.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared encodings for the CPU-to-timer-device bridge: FSM states, register
// offsets, default device bases and hwint bit positions.
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] OFF_CTRL   = 32'd0;
    localparam logic [31:0] OFF_PRESET = 32'd4;
    localparam logic [31:0] OFF_COUNT  = 32'd8;

    localparam logic [31:0] DEF_DEV0_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEF_DEV1_BASE = 32'h0000_7F10;
    localparam logic [31:0] DEF_DEV_SPAN  = 32'd12;

    // Positions inside hwint[5:0], which carries CP0 interrupt lines [7:2].
    localparam int HWINT_DEV0 = 0;
    localparam int HWINT_DEV1 = 1;
    localparam int HWINT_EXT  = 2;

endpackage

// File: rtl/bridge_decode.sv
// Combinational address decode for the bridge. With BRIDGE_RO_ERR_EN defined,
// stores to the read-only COUNT register are reported as faults.
module bridge_decode
    import bridge_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEF_DEV0_BASE,
    parameter logic [31:0] DEV1_BASE = DEF_DEV1_BASE,
    parameter logic [31:0] DEV_SPAN  = DEF_DEV_SPAN
) (
    input  logic [31:0] addr,
    input  logic        we,
    output logic        sel0,
    output logic        sel1,
    output logic        err
);

`ifdef BRIDGE_RO_ERR_EN
    localparam bit RO_ERR = 1'b1;
`else
    localparam bit RO_ERR = 1'b0;
`endif

    logic        hit0;
    logic        hit1;
    logic        misaligned;
    logic        ro_err;
    logic [31:0] off;

    always_comb begin
        hit0       = (addr >= DEV0_BASE) && (addr < DEV0_BASE + DEV_SPAN);
        hit1       = (addr >= DEV1_BASE) && (addr < DEV1_BASE + DEV_SPAN);
        misaligned = (addr[1:0] != 2'b00);
        off        = hit0 ? (addr - DEV0_BASE) : (addr - DEV1_BASE);
        ro_err     = RO_ERR && we && (hit0 || hit1) && (off == OFF_COUNT);
        err        = misaligned || !(hit0 || hit1) || ro_err;
        // A faulting access selects nothing, so no strobe can leak out.
        sel0       = hit0 && !err;
        sel1       = hit1 && !err;
    end

endmodule

// File: rtl/sys_bridge.sv
// CPU load/store initiator for two timer/counter devices with fixed 3-cycle
// turnaround, plus registered hwint vector. Optional macro: BRIDGE_RO_ERR_EN.
module sys_bridge
    import bridge_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEF_DEV0_BASE,
    parameter logic [31:0] DEV1_BASE = DEF_DEV1_BASE,
    parameter logic [31:0] DEV_SPAN  = DEF_DEV_SPAN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [29:0] dev0_addr,
    output logic        dev0_we,
    output logic [31:0] dev0_din,
    input  logic [31:0] dev0_dout,
    input  logic        dev0_irq,
    output logic [29:0] dev1_addr,
    output logic        dev1_we,
    output logic [31:0] dev1_din,
    input  logic [31:0] dev1_dout,
    input  logic        dev1_irq,
    input  logic        ext_irq,
    output logic [5:0]  hwint
);

    state_t      state;
    state_t      state_next;
    logic        dec_sel0;
    logic        dec_sel1;
    logic        dec_err;
    logic        accept;
    logic        sel0_q;
    logic        sel1_q;
    logic        err_q;
    logic        we_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [5:0]  hwint_q;

    bridge_decode #(
        .DEV0_BASE (DEV0_BASE),
        .DEV1_BASE (DEV1_BASE),
        .DEV_SPAN  (DEV_SPAN)
    ) u_decode (
        .addr (cpu_addr),
        .we   (cpu_we),
        .sel0 (dec_sel0),
        .sel1 (dec_sel1),
        .err  (dec_err)
    );

    assign accept = (state == ST_IDLE) && cpu_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            sel0_q  <= 1'b0;
            sel1_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            hwint_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                sel0_q <= dec_sel0;
                sel1_q <= dec_sel1;
                err_q  <= dec_err;
                we_q   <= cpu_we;
            end
            if (state == ST_ACC) begin
                if (sel0_q && !we_q)
                    rdata_q <= dev0_dout;
                else if (sel1_q && !we_q)
                    rdata_q <= dev1_dout;
                else
                    rdata_q <= '0;
            end
            hwint_q                <= '0;
            hwint_q[HWINT_DEV0]    <= dev0_irq;
            hwint_q[HWINT_DEV1]    <= dev1_irq;
            hwint_q[HWINT_EXT]     <= ext_irq;
        end
    end

    // Payload only matters while qualified by state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= cpu_addr[31:2];
            wdata_q <= cpu_wdata;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cpu_req) state_next = ST_ACC;
            ST_ACC:  state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dev0_addr = '0;
        dev0_we   = 1'b0;
        dev0_din  = '0;
        dev1_addr = '0;
        dev1_we   = 1'b0;
        dev1_din  = '0;
        if (state == ST_ACC) begin
            if (sel0_q) begin
                dev0_addr = addr_q;
                dev0_we   = we_q;
                dev0_din  = wdata_q;
            end
            if (sel1_q) begin
                dev1_addr = addr_q;
                dev1_we   = we_q;
                dev1_din  = wdata_q;
            end
        end
    end

    assign cpu_ready = (state == ST_RESP);
    assign cpu_err   = (state == ST_RESP) && err_q;
    assign cpu_rdata = rdata_q;
    assign hwint     = hwint_q;

endmodule

// File: tb/tb_sys_bridge.sv
// Directed bench for sys_bridge: decode, timing, faults, reset abort, hwint.
module tb_sys_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [29:0] dev0_addr;
    logic        dev0_we;
    logic [31:0] dev0_din;
    logic [31:0] dev0_dout;
    logic        dev0_irq;
    logic [29:0] dev1_addr;
    logic        dev1_we;
    logic [31:0] dev1_din;
    logic [31:0] dev1_dout;
    logic        dev1_irq;
    logic        ext_irq;
    logic [5:0]  hwint;

    int checks = 0;
    int errors = 0;
    int ready_cnt;

    always #5 clk = ~clk;

    sys_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .dev0_addr (dev0_addr),
        .dev0_we   (dev0_we),
        .dev0_din  (dev0_din),
        .dev0_dout (dev0_dout),
        .dev0_irq  (dev0_irq),
        .dev1_addr (dev1_addr),
        .dev1_we   (dev1_we),
        .dev1_din  (dev1_din),
        .dev1_dout (dev1_dout),
        .dev1_irq  (dev1_irq),
        .ext_irq   (ext_irq),
        .hwint     (hwint)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, lets the accept edge pass; caller is then in ACC.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        step();
        cpu_req   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dev0_dout = '0; dev1_dout = '0; dev0_irq = 1'b0; dev1_irq = 1'b0; ext_irq = 1'b0;
        #1;
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_err",   {31'd0, cpu_err},   32'd0);
        chk("rst_rdata", cpu_rdata,          32'd0);
        chk("rst_d0we",  {31'd0, dev0_we},   32'd0);
        chk("rst_d0addr",{2'b0, dev0_addr},  32'd0);
        chk("rst_d1din", dev1_din,           32'd0);
        chk("rst_hwint", {26'd0, hwint},     32'd0);
        step(); step();
        reset = 1'b0;
        step();

        // Test 1: load dev0 PRESET
        dev0_dout = 32'h0000_0010;
        issue(1'b0, 32'h0000_7F04, 32'h0);
        chk("t1_acc_addr", {2'b0, dev0_addr}, 32'h0000_1FC1);
        chk("t1_acc_we",   {31'd0, dev0_we},  32'd0);
        chk("t1_acc_ready",{31'd0, cpu_ready},32'd0);
        chk("t1_d1addr",   {2'b0, dev1_addr}, 32'd0);
        step();
        chk("t1_ready", {31'd0, cpu_ready}, 32'd1);
        chk("t1_rdata", cpu_rdata,          32'h0000_0010);
        chk("t1_err",   {31'd0, cpu_err},   32'd0);
        step();
        chk("t1_ready_drop", {31'd0, cpu_ready}, 32'd0);

        // Test 2: store dev1 CTRL
        issue(1'b1, 32'h0000_7F10, 32'h0000_0009);
        chk("t2_d1we",   {31'd0, dev1_we},  32'd1);
        chk("t2_d1din",  dev1_din,          32'd9);
        chk("t2_d1addr", {2'b0, dev1_addr}, 32'h0000_1FC4);
        chk("t2_d0we",   {31'd0, dev0_we},  32'd0);
        step();
        chk("t2_d1we_off", {31'd0, dev1_we},  32'd0);
        chk("t2_ready",    {31'd0, cpu_ready},32'd1);
        chk("t2_err",      {31'd0, cpu_err},  32'd0);
        chk("t2_rdata",    cpu_rdata,         32'd0);
        step();

        // Test 3: unmapped load and misaligned store
        dev0_dout = 32'hDEAD_0001; dev1_dout = 32'hDEAD_0002;
        issue(1'b0, 32'h0000_7F20, 32'h0);
        chk("t3a_d0addr", {2'b0, dev0_addr}, 32'd0);
        chk("t3a_d1addr", {2'b0, dev1_addr}, 32'd0);
        step();
        chk("t3a_ready", {31'd0, cpu_ready}, 32'd1);
        chk("t3a_err",   {31'd0, cpu_err},   32'd1);
        chk("t3a_rdata", cpu_rdata,          32'd0);
        step();
        issue(1'b1, 32'h0000_7F02, 32'h0000_00FF);
        chk("t3b_d0we", {31'd0, dev0_we}, 32'd0);
        chk("t3b_d1we", {31'd0, dev1_we}, 32'd0);
        step();
        chk("t3b_ready", {31'd0, cpu_ready}, 32'd1);
        chk("t3b_err",   {31'd0, cpu_err},   32'd1);
        step();

        // Test 4: interrupt vector
        dev1_irq = 1'b1;
        chk("t4_pre", {26'd0, hwint}, 32'd0);
        step();
        chk("t4_dev1", {26'd0, hwint}, 32'b000010);
        ext_irq = 1'b1;
        step();
        chk("t4_ext", {26'd0, hwint}, 32'b000110);
        dev0_irq = 1'b1;
        step();
        chk("t4_all", {26'd0, hwint}, 32'b000111);
        dev0_irq = 1'b0; dev1_irq = 1'b0; ext_irq = 1'b0;
        step();
        chk("t4_clear", {26'd0, hwint}, 32'd0);

        // Test 5: reset during a store's ACC cycle
        issue(1'b1, 32'h0000_7F00, 32'h0000_0005);
        chk("t5_we_acc", {31'd0, dev0_we}, 32'd1);
        chk("t5_din",    dev0_din,         32'd5);
        #2 reset = 1'b1;
        #1;
        chk("t5_we_drop",  {31'd0, dev0_we},  32'd0);
        chk("t5_addr_rst", {2'b0, dev0_addr}, 32'd0);
        #1 reset = 1'b0;
        ready_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (cpu_ready || dev0_we) ready_cnt++;
        end
        chk("t5_no_resp", ready_cnt, 32'd0);
        dev0_dout = 32'h0000_1234;
        issue(1'b0, 32'h0000_7F08, 32'h0);
        chk("t5_next_addr", {2'b0, dev0_addr}, 32'h0000_1FC2);
        step();
        chk("t5_next_ready", {31'd0, cpu_ready}, 32'd1);
        chk("t5_next_rdata", cpu_rdata,          32'h0000_1234);
        chk("t5_next_err",   {31'd0, cpu_err},   32'd0);
        step();

        // Test 6: store to COUNT
        issue(1'b1, 32'h0000_7F08, 32'h0000_0077);
`ifdef BRIDGE_RO_ERR_EN
        chk("t6_we", {31'd0, dev0_we}, 32'd0);
        step();
        chk("t6_err", {31'd0, cpu_err}, 32'd1);
`else
        chk("t6_we", {31'd0, dev0_we}, 32'd1);
        step();
        chk("t6_err", {31'd0, cpu_err}, 32'd0);
`endif
        chk("t6_ready", {31'd0, cpu_ready}, 32'd1);
        step();

        // Held request: one response every three cycles, req ignored mid-access
        dev1_dout = 32'h0000_ABCD;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7F14;
        ready_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) cpu_req = 1'b0;
            if (cpu_ready) begin
                ready_cnt++;
                chk("b2b_rdata", cpu_rdata, 32'h0000_ABCD);
            end
            if (i == 2 || i == 5) chk("b2b_ready_slot", {31'd0, cpu_ready}, 32'd1);
        end
        chk("b2b_count", ready_cnt, 32'd2);
        step();
        chk("b2b_idle", {31'd0, cpu_ready}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
